// File: rtl/delay_chain_sensor.sv
// Inverting delay-chain timing sensor: launches edges into a tapped chain, decodes how far
// each edge travelled in one clock and averages over a window. Optional DELAY_CHAIN_SENSOR_MINMAX_EN adds min/max outputs.
module delay_chain_sensor #(
  parameter int CHAIN_LEN   = 100,
  parameter int SAMPLE_LOG2 = 4,
  parameter int SETTLE_CYC  = 4,
  localparam int CW = $clog2(CHAIN_LEN + 1),
  localparam int AW = CW + SAMPLE_LOG2
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sumCount,
  output logic [CW-1:0] avgCount,
  output logic          bubbleErr
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  ,
  output logic [CW-1:0] minCount,
  output logic [CW-1:0] maxCount
`endif
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, PREP, LAUNCH, CAP, SYNC, ACC, DONE} stateT;

  stateT stateReg, stateNext;

  logic                   launchReg;
  logic [CHAIN_LEN-1:0]   chainOut;
  logic [CHAIN_LEN-1:0]   tapW;
  logic [CHAIN_LEN-1:0]   capReg;
  logic [CHAIN_LEN-1:0]   capSync;
  logic [CHAIN_LEN-1:0]   tNorm;
  logic [SW-1:0]          settleCnt;
  logic [SAMPLE_LOG2-1:0] sampleCnt;
  logic [AW-1:0]          sumReg;
  logic                   busyReg;
  logic                   doneReg;
  logic                   bubbleReg;
  logic [CW-1:0]          tapCount;
  logic                   bubbleNow;
  logic                   seenZero;
  logic                   settleDone;
  logic                   lastSample;
  logic                   winClear;
  logic                   accEn;
  logic                   settleInc;
  logic                   launchNext;
  logic                   busyNext;
  logic                   doneNext;

  // Each stage is one inverter; stage 0 is driven by the launch register.
  for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : gStage
    logic stageIn;
    logic stageOut;
    if (gi == 0) begin : gFirst
      assign stageIn = launchReg;
    end else begin : gNext
      assign stageIn = gStage[gi-1].stageOut;
    end
    assign stageOut     = ~stageIn;
    assign chainOut[gi] = stageOut;
  end

  assign tapW = chainOut;

  // Even stages invert a rising launch edge into a low tap, so flip them back.
  for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : gNorm
    assign tNorm[gi] = capSync[gi] ^ ((gi % 2) == 0);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      capReg  <= '0;
      capSync <= '0;
    end else begin
      capReg  <= tapW;
      capSync <= capReg;
    end
  end

  // Leading-ones count; any one seen after the first zero is a bubble.
  always_comb begin
    tapCount  = '0;
    bubbleNow = 1'b0;
    seenZero  = 1'b0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      if (!tNorm[k]) begin
        seenZero = 1'b1;
      end else if (seenZero) begin
        bubbleNow = 1'b1;
      end else begin
        tapCount = tapCount + CW'(1);
      end
    end
  end

  assign settleDone = (settleCnt == SW'(SETTLE_CYC - 1));
  assign lastSample = (sampleCnt == '1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = PREP;
      PREP:    if (settleDone) stateNext = LAUNCH;
      LAUNCH:  stateNext = CAP;
      CAP:     stateNext = SYNC;
      SYNC:    stateNext = ACC;
      ACC:     stateNext = lastSample ? DONE : PREP;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    winClear   = (stateReg == IDLE) && start;
    settleInc  = (stateReg == PREP) && !settleDone;
    accEn      = (stateReg == ACC);
    launchNext = (stateNext == CAP) || (stateNext == SYNC) || (stateNext == ACC);
    doneNext   = (stateReg == DONE);
    busyNext   = busyReg;
    if (winClear) begin
      busyNext = 1'b1;
    end else if (stateReg == DONE) begin
      busyNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      launchReg <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      settleCnt <= '0;
      sampleCnt <= '0;
      sumReg    <= '0;
      bubbleReg <= 1'b0;
    end else begin
      launchReg <= launchNext;
      busyReg   <= busyNext;
      doneReg   <= doneNext;
      if (winClear || (stateReg == PREP && settleDone)) begin
        settleCnt <= '0;
      end else if (settleInc) begin
        settleCnt <= settleCnt + SW'(1);
      end
      if (winClear) begin
        sampleCnt <= '0;
        sumReg    <= '0;
        bubbleReg <= 1'b0;
      end else if (accEn) begin
        sampleCnt <= sampleCnt + SAMPLE_LOG2'(1);
        sumReg    <= sumReg + AW'(tapCount);
        bubbleReg <= bubbleReg | bubbleNow;
      end
    end
  end

`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  logic [CW-1:0] minReg;
  logic [CW-1:0] maxReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      minReg <= '0;
      maxReg <= '0;
    end else if (winClear) begin
      minReg <= CW'(CHAIN_LEN);
      maxReg <= '0;
    end else if (accEn) begin
      if (tapCount < minReg) minReg <= tapCount;
      if (tapCount > maxReg) maxReg <= tapCount;
    end
  end

  assign minCount = minReg;
  assign maxCount = maxReg;
`endif

  assign busy      = busyReg;
  assign done      = doneReg;
  assign sumCount  = sumReg;
  assign avgCount  = sumReg[AW-1:SAMPLE_LOG2];
  assign bubbleErr = bubbleReg;

endmodule

// File: tb/tb_delay_chain_sensor.sv
// Directed bench for delay_chain_sensor: zero-delay chain, forced tap patterns,
// busy/start interaction and mid-window reset abort.
module tb_delay_chain_sensor;

  localparam int CHAIN_LEN = 100;
  localparam int CW        = 7;
  localparam int AW        = 11;
  localparam int WIN_LAT   = 129;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] sumCount;
  logic [CW-1:0] avgCount;
  logic          bubbleErr;
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  logic [CW-1:0] minCount;
  logic [CW-1:0] maxCount;
`endif

  int checkCount = 0;
  int errorCount = 0;
  logic [CHAIN_LEN-1:0] evenMask;
  logic [CHAIN_LEN-1:0] rawPat;

  always #5 clk = ~clk;

  delay_chain_sensor dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sumCount  (sumCount),
    .avgCount  (avgCount),
    .bubbleErr (bubbleErr)
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    ,
    .minCount  (minCount),
    .maxCount  (maxCount)
`endif
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // mode 0: real chain; 1: 37 leading ones; 2: 40 ones, sample 3 has ones at 0..9 and 12
  task automatic applyPattern(input int mode, input int sampleIdx);
    logic [CHAIN_LEN-1:0] t;
    int ones;
    if (mode == 0) return;
    t = '0;
    if (mode == 2 && sampleIdx == 3) begin
      for (int k = 0; k < 10; k++) t[k] = 1'b1;
      t[12] = 1'b1;
    end else begin
      ones = (mode == 1) ? 37 : 40;
      for (int k = 0; k < ones; k++) t[k] = 1'b1;
    end
    rawPat = t ^ evenMask;
    force dut.tapW = rawPat;
  endtask

  task automatic issueStart(input int mode);
    @(negedge clk);
    applyPattern(mode, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkValue("busyAfterStart", 32'(busy), 1);
  endtask

  // Called at the negedge just after the accepting edge; returns edges until done is seen.
  task automatic waitDone(input int mode, input int pokeAt, input int holdFrom, output int lat);
    bit found;
    lat = 0;
    found = 0;
    while (!found && lat < 400) begin
      applyPattern(mode, lat / 8);
      start = (lat == pokeAt) || (holdFrom >= 0 && lat >= holdFrom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) found = 1;
    end
    if (!found) checkValue("doneTimeout", 0, 1);
  endtask

  task automatic runWindow(input string name, input int mode, input int expSum, input int expAvg,
                           input int expBub, input int expMin, input int expMax);
    int lat;
    issueStart(mode);
    waitDone(mode, -1, -1, lat);
    checkValue({name, "_latency"}, 32'(lat), WIN_LAT);
    checkValue({name, "_sum"}, 32'(sumCount), 32'(expSum));
    checkValue({name, "_avg"}, 32'(avgCount), 32'(expAvg));
    checkValue({name, "_bubble"}, 32'(bubbleErr), 32'(expBub));
    checkValue({name, "_busyLow"}, 32'(busy), 0);
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    checkValue({name, "_min"}, 32'(minCount), 32'(expMin));
    checkValue({name, "_max"}, 32'(maxCount), 32'(expMax));
`else
    if (expMin > expMax) checkValue({name, "_minmaxArgs"}, 32'(expMin), 32'(expMax));
`endif
    @(posedge clk);
    @(negedge clk);
    checkValue({name, "_doneOnce"}, 32'(done), 0);
    if (mode != 0) release dut.tapW;
    $display("window %s: latency=%0d sum=%0d avg=%0d bubble=%0d", name, lat, sumCount, avgCount, bubbleErr);
  endtask

  initial begin
    int lat;
    int doneSeen;
    int launchSeen;
    for (int k = 0; k < CHAIN_LEN; k++) evenMask[k] = ((k % 2) == 0);

    // Reset and idle
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    checkValue("rst_busy", 32'(busy), 0);
    checkValue("rst_done", 32'(done), 0);
    checkValue("rst_sum", 32'(sumCount), 0);
    checkValue("rst_avg", 32'(avgCount), 0);
    checkValue("rst_bubble", 32'(bubbleErr), 0);
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    checkValue("rst_min", 32'(minCount), 0);
    checkValue("rst_max", 32'(maxCount), 0);
`endif
    launchSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.launchReg) launchSeen++;
    end
    checkValue("idle_launchLow", 32'(launchSeen), 0);
    $display("reset/idle: busy=%0d sum=%0d", busy, sumCount);

    // Zero-delay chain, forced thermometer, forced bubble
    runWindow("zeroDelay", 0, 1600, 100, 0, 100, 100);
    runWindow("therm37", 1, 592, 37, 0, 37, 37);
    repeat (5) @(negedge clk);
    checkValue("hold_sum", 32'(sumCount), 592);
    checkValue("hold_avg", 32'(avgCount), 37);
    runWindow("bubble", 2, 610, 38, 1, 10, 40);

    // start poked while busy, then held across done
    issueStart(0);
    waitDone(0, 50, 120, lat);
    checkValue("busyWin_latency", 32'(lat), WIN_LAT);
    checkValue("busyWin_busyLow", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    checkValue("restart_busy", 32'(busy), 1);
    checkValue("restart_doneLow", 32'(done), 0);
    start = 1'b0;
    waitDone(0, -1, -1, lat);
    checkValue("restart_latency", 32'(lat), WIN_LAT);
    checkValue("restart_sum", 32'(sumCount), 1600);
    @(posedge clk);
    @(negedge clk);
    checkValue("restart_doneOnce", 32'(done), 0);
    $display("window restart: latency=%0d sum=%0d avg=%0d", lat, sumCount, avgCount);

    // Reset during sample 5 ACC
    issueStart(0);
    repeat (47) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkValue("abort_partialSum", 32'(sumCount), 500);
    #1 rstN = 1'b0;
    #1;
    checkValue("abort_busy", 32'(busy), 0);
    checkValue("abort_done", 32'(done), 0);
    checkValue("abort_sum", 32'(sumCount), 0);
    checkValue("abort_avg", 32'(avgCount), 0);
    checkValue("abort_launch", 32'(dut.launchReg), 0);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkValue("abort_noDone", 32'(doneSeen), 0);
    $display("abort: sum=%0d busy=%0d dones=%0d", sumCount, busy, doneSeen);
    runWindow("afterAbort", 0, 1600, 100, 0, 100, 100);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
